// File: rtl/pipe_pkg.sv
// Shared types for the generic inter-stage pipeline register.
//   pipe_entry_t : one pipeline slot (control, payload, restart PC, status
//                  flags) at the default 32-bit widths. Instances using
//                  other widths declare a local struct with the same fields.
//   skid_state_e : occupancy of the optional 1-entry skid buffer.
package pipe_pkg;

  localparam int unsigned PIPE_CTRL_W = 32;
  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_PC_W   = 32;

  typedef struct packed {
    logic [PIPE_CTRL_W-1:0] ctrl;
    logic [PIPE_DATA_W-1:0] data;
    logic [PIPE_PC_W-1:0]   rpc;
    logic                   valid;
    logic                   is_flushed;
    logic                   is_bds;
  } pipe_entry_t;

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer that registers the backward stall.
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset
//   in_entry    : entry formed from stage N this cycle
//   dn_stall    : stage N+1 cannot accept
//   kill        : discard the held entry and drop the stall
//   skid_entry  : entry parked while stage N+1 was stalled
//   full        : skid_entry holds a live entry
//   up_stall    : registered stall towards stage N
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter type entry_t = pipe_entry_t
) (
  input  logic   CLK,
  input  logic   RST_N,
  input  entry_t in_entry,
  input  logic   dn_stall,
  input  logic   kill,
  output entry_t skid_entry,
  output logic   full,
  output logic   up_stall
);

  skid_state_e state_q, state_d;
  logic        load;

  // Stage N only learns about dn_stall a cycle late, so the entry it
  // hands over during that cycle is parked here instead of dropped.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (kill) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (dn_stall && !up_stall) begin
            state_d = SKID_FULL;
            load    = 1'b1;
          end
        end
        SKID_FULL: begin
          if (!dn_stall) state_d = SKID_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= SKID_EMPTY;
      up_stall   <= 1'b0;
      skid_entry <= '0;
    end else begin
      state_q  <= state_d;
      up_stall <= !kill && (dn_stall || (state_d == SKID_FULL));
      if (load) skid_entry <= in_entry;
    end
  end

  assign full = (state_q == SKID_FULL);

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register (generic successor of IF/ID).
// Ports:
//   CLK, RST_N       : clock, asynchronous active-low reset
//   in_ctrl/in_data  : control word / payload from stage N
//   in_pc, in_is_bds : PC of the instruction, delay-slot flag
//   in_bubble        : stage N output is not a real instruction
//   in_flush         : flush the incoming instruction
//   kill             : flush everything held here, overrides stalls
//   dn_stall         : stage N+1 cannot accept
//   up_stall         : stall to stage N (registered when SKID=1)
//   out_*            : entry presented to stage N+1
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       PC_W     = 32,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter bit                SKID     = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_is_bds,
  input  logic              in_bubble,
  input  logic              in_flush,
  input  logic              kill,
  input  logic              dn_stall,
  output logic              up_stall,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_restart_pc,
  output logic              out_valid,
  output logic              out_is_flushed,
  output logic              out_is_bds
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   rpc;
    logic              valid;
    logic              is_flushed;
    logic              is_bds;
  } entry_t;

  entry_t          formed;
  entry_t          next_out;
  entry_t          out_q;
  logic [PC_W-1:0] last_rpc;
  logic            accept;

  // A delay slot restarts at its branch, so it inherits the last non-BDS PC.
  always_comb begin
    formed.ctrl       = (in_bubble || in_flush) ? NOP_CTRL : in_ctrl;
    formed.data       = in_data;
    formed.rpc        = in_is_bds ? last_rpc : in_pc;
    formed.valid      = !in_bubble && !in_flush;
    formed.is_flushed = in_flush;
    formed.is_bds     = in_is_bds;
  end

  assign accept = !up_stall && !kill;

  if (SKID) begin : g_skid
    entry_t skid_entry;
    logic   skid_full;

    pipe_skid_buf #(
      .entry_t(entry_t)
    ) u_skid (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_entry  (formed),
      .dn_stall  (dn_stall),
      .kill      (kill),
      .skid_entry(skid_entry),
      .full      (skid_full),
      .up_stall  (up_stall)
    );

    // A parked entry is older than anything at the input, so it drains first.
    assign next_out = skid_full ? skid_entry : formed;
  end else begin : g_pass
    assign up_stall = dn_stall;
    assign next_out = formed;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q.ctrl       <= NOP_CTRL;
      out_q.data       <= '0;
      out_q.rpc        <= '0;
      out_q.valid      <= 1'b0;
      out_q.is_flushed <= 1'b0;
      out_q.is_bds     <= 1'b0;
      last_rpc         <= '0;
    end else begin
      if (kill) begin
        // Data, restart PC and BDS flag stay for exception reporting.
        out_q.ctrl       <= NOP_CTRL;
        out_q.valid      <= 1'b0;
        out_q.is_flushed <= 1'b1;
      end else if (!dn_stall) begin
        out_q <= next_out;
      end
      if (accept && !in_is_bds) last_rpc <= in_pc;
    end
  end

  assign out_ctrl       = out_q.ctrl;
  assign out_data       = out_q.data;
  assign out_restart_pc = out_q.rpc;
  assign out_valid      = out_q.valid;
  assign out_is_flushed = out_q.is_flushed;
  assign out_is_bds     = out_q.is_bds;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP1 = 32'h0000_0000;
  localparam logic [31:0] NOP0 = 32'h0000_0013;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic [31:0] in_ctrl, in_data, in_pc;
  logic        in_is_bds, in_bubble, in_flush, kill, dn_stall;

  logic        up1, ov1, of1, ob1;
  logic [31:0] oc1, od1, orp1;
  logic        up0, ov0, of0, ob0;
  logic [31:0] oc0, od0, orp0;

  pipe_stage_reg #(
    .CTRL_W(32), .DATA_W(32), .PC_W(32), .NOP_CTRL(NOP1), .SKID(1'b1)
  ) u_skid (
    .CLK(CLK), .RST_N(RST_N), .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
    .in_is_bds(in_is_bds), .in_bubble(in_bubble), .in_flush(in_flush), .kill(kill),
    .dn_stall(dn_stall), .up_stall(up1), .out_ctrl(oc1), .out_data(od1),
    .out_restart_pc(orp1), .out_valid(ov1), .out_is_flushed(of1), .out_is_bds(ob1)
  );

  pipe_stage_reg #(
    .CTRL_W(32), .DATA_W(32), .PC_W(32), .NOP_CTRL(NOP0), .SKID(1'b0)
  ) u_pass (
    .CLK(CLK), .RST_N(RST_N), .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
    .in_is_bds(in_is_bds), .in_bubble(in_bubble), .in_flush(in_flush), .kill(kill),
    .dn_stall(dn_stall), .up_stall(up0), .out_ctrl(oc0), .out_data(od0),
    .out_restart_pc(orp0), .out_valid(ov0), .out_is_flushed(of0), .out_is_bds(ob0)
  );

  // Reference model: a queue of accepted-but-not-presented entries for the
  // skid instance (stage N is stalled whenever that backlog is non-empty),
  // and a direct load-when-not-stalled register for the pass-through one.
  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] data;
    logic [31:0] rpc;
    logic        valid;
    logic        fl;
    logic        bds;
  } ent_t;

  ent_t        m1_out, m0_out;
  ent_t        m1_q[$];
  logic [31:0] m1_lrpc, m0_lrpc;
  logic        m1_up;
  logic        acc1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] src[$];
  logic [31:0] seen[$];
  logic [31:0] want[4];
  bit          dn_pat[10];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t form(input logic [31:0] nop, input logic [31:0] lrpc);
    ent_t e;
    e.ctrl  = (in_bubble || in_flush) ? nop : in_ctrl;
    e.data  = in_data;
    e.rpc   = in_is_bds ? lrpc : in_pc;
    e.valid = !in_bubble && !in_flush;
    e.fl    = in_flush;
    e.bds   = in_is_bds;
    return e;
  endfunction

  function automatic ent_t rst_ent(input logic [31:0] nop);
    ent_t e;
    e.ctrl = nop; e.data = 32'h0; e.rpc = 32'h0;
    e.valid = 1'b0; e.fl = 1'b0; e.bds = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    m1_out = rst_ent(NOP1);
    m0_out = rst_ent(NOP0);
    m1_q.delete();
    m1_lrpc = 32'h0;
    m0_lrpc = 32'h0;
    m1_up   = 1'b0;
  endtask

  task automatic model_edge();
    if (kill) begin
      m1_q.delete();
      m1_out.ctrl = NOP1; m1_out.valid = 1'b0; m1_out.fl = 1'b1;
      m1_up = 1'b0;
      m0_out.ctrl = NOP0; m0_out.valid = 1'b0; m0_out.fl = 1'b1;
    end else begin
      if (!m1_up) begin
        m1_q.push_back(form(NOP1, m1_lrpc));
        if (!in_is_bds) m1_lrpc = in_pc;
      end
      if (!dn_stall && m1_q.size() != 0) m1_out = m1_q.pop_front();
      m1_up = (m1_q.size() != 0);
      if (!dn_stall) begin
        m0_out = form(NOP0, m0_lrpc);
        if (!in_is_bds) m0_lrpc = in_pc;
      end
    end
  endtask

  task automatic compare_all();
    chk("skid.ctrl",     oc1,         m1_out.ctrl);
    chk("skid.data",     od1,         m1_out.data);
    chk("skid.rpc",      orp1,        m1_out.rpc);
    chk("skid.valid",    32'(ov1),    32'(m1_out.valid));
    chk("skid.flushed",  32'(of1),    32'(m1_out.fl));
    chk("skid.bds",      32'(ob1),    32'(m1_out.bds));
    chk("skid.up_stall", 32'(up1),    32'(m1_up));
    chk("pass.ctrl",     oc0,         m0_out.ctrl);
    chk("pass.data",     od0,         m0_out.data);
    chk("pass.rpc",      orp0,        m0_out.rpc);
    chk("pass.valid",    32'(ov0),    32'(m0_out.valid));
    chk("pass.flushed",  32'(of0),    32'(m0_out.fl));
    chk("pass.bds",      32'(ob0),    32'(m0_out.bds));
    chk("pass.up_stall", 32'(up0),    32'(dn_stall));
  endtask

  task automatic drive(input logic [31:0] c, input logic [31:0] d, input logic [31:0] p,
                       input logic bds, input logic bub, input logic fl,
                       input logic k, input logic dn);
    in_ctrl = c; in_data = d; in_pc = p;
    in_is_bds = bds; in_bubble = bub; in_flush = fl; kill = k; dn_stall = dn;
  endtask

  // Check at the falling edge, advance model with the DUT on the rising edge.
  task automatic tick();
    @(negedge CLK);
    compare_all();
    @(posedge CLK);
    acc1 = !m1_up && !kill;
    model_edge();
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    chk("rst.ctrl_skid", oc1, NOP1);
    chk("rst.ctrl_pass", oc0, NOP0);
    chk("rst.valid",     32'(ov1), 32'd0);
    chk("rst.up_stall",  32'(up1), 32'd0);

    // Plain stream, no stalls.
    for (int unsigned i = 0; i < 4; i++) begin
      drive(32'h1111_0001 + i, 32'h104 + 4 * i, 32'h100 + 4 * i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("stream.ctrl",  oc1, 32'h1111_0001 + i);
      chk("stream.rpc",   orp1, 32'h100 + 4 * i);
      chk("stream.valid", 32'(ov1), 32'd1);
      chk("stream.pass",  oc0, 32'h1111_0001 + i);
    end

    // Branch then delay slot.
    drive(32'h0000_0063, 32'h204, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'hAAAA_0001, 32'h208, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bds.rpc",      orp1, 32'h200);
    chk("bds.flag",     32'(ob1), 32'd1);
    chk("bds.rpc_pass", orp0, 32'h200);

    // Flushed input.
    drive(32'hDEAD_BEEF, 32'h304, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("flush.ctrl",      oc1, 32'h0);
    chk("flush.valid",     32'(ov1), 32'd0);
    chk("flush.flushed",   32'(of1), 32'd1);
    chk("flush.data",      od1, 32'h304);
    chk("flush.ctrl_pass", oc0, NOP0);

    // Stream A..D with dn_stall high for three cycles; bench acts as stage N.
    src  = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D};
    want = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D};
    dn_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    seen.delete();
    for (int unsigned c = 0; c < 10; c++) begin
      if (src.size() != 0)
        drive(src[0], src[0] ^ 32'h0000_FFFF, src[0] & 32'h0000_0FFC, 1'b0, 1'b0, 1'b0, 1'b0, dn_pat[c]);
      else
        drive(32'h0, 32'h0, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, dn_pat[c]);
      if (ov1 && !dn_pat[c]) seen.push_back(oc1);
      if (c == 1) chk("skid.up_at_rise", 32'(up1), 32'd0);
      if (c == 2) chk("skid.up_next",    32'(up1), 32'd1);
      tick();
      if (acc1 && src.size() != 0) void'(src.pop_front());
    end
    chk("skid.seq_len", 32'(seen.size()), 32'd4);
    for (int unsigned i = 0; i < 4; i++)
      chk("skid.seq", (i < seen.size()) ? seen[i] : 32'hXXXX_XXXX, want[i]);

    // Kill while the skid is full and downstream stalled.
    drive(32'hE000_000E, 32'h600, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'hF000_000F, 32'h604, 32'h604, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("kill.pre_up", 32'(up1), 32'd1);
    drive(32'h6000_0006, 32'h608, 32'h608, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("kill.valid",    32'(ov1), 32'd0);
    chk("kill.flushed",  32'(of1), 32'd1);
    chk("kill.up",       32'(up1), 32'd0);
    chk("kill.data",     od1,  32'h600);
    chk("kill.rpc",      orp1, 32'h600);
    drive(32'h7000_0007, 32'h60C, 32'h60C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("kill.skid_empty", oc1, 32'h7000_0007);

    // Asynchronous reset while the skid is full.
    drive(32'h8000_0008, 32'h700, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h9000_0009, 32'h704, 32'h704, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("arst.pre_up", 32'(up1), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("arst.ctrl",      oc1,  NOP1);
    chk("arst.data",      od1,  32'h0);
    chk("arst.rpc",       orp1, 32'h0);
    chk("arst.valid",     32'(ov1), 32'd0);
    chk("arst.up",        32'(up1), 32'd0);
    chk("arst.ctrl_pass", oc0,  NOP0);
    model_reset();
    #1;
    RST_N = 1'b1;
    drive(32'hAB00_0001, 32'h800, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("arst.skid_empty", oc1, 32'hAB00_0001);

    // Randomised traffic against the model.
    for (int unsigned c = 0; c < 400; c++) begin
      drive($urandom, $urandom, $urandom & 32'hFFFF_FFFC,
            ($urandom_range(3) == 0), ($urandom_range(7) == 0), ($urandom_range(7) == 0),
            ($urandom_range(31) == 0), ($urandom_range(2) == 0));
      tick();
    end
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
